score_event_gen: RTL and testbench

- Produces the `increment_score_pe` pulse that the processor consumes to bump the score register.
- Synchronizes and debounces the raw prize-drop sensor from the claw cabinet, then queues detected drops.
- Emits each queued drop as a single-cycle pulse, with a guaranteed gap between pulses so the processor never misses one.
- Sits between the cabinet I/O pin and the processor wrapper's `increment_score_pe` input.

---
 rtl/score_pkg.sv | 17 +
 rtl/score_event_gen_if.sv | 31 +++
 rtl/prize_debounce.sv | 52 +++++
 rtl/score_event_gen.sv | 109 ++++++++++
 tb/tb_score_event_gen.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// Shared types and default sizing for the prize-drop score event generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: launch FSM state enum and the default parameter values.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_GAP_CYCLES      = 4;
  localparam int DEF_PEND_W          = 4;

endpackage

// File: rtl/score_event_gen_if.sv
// Cabinet-side bundle: raw prize sensor and launch enable in, score pulse and status out.
// Latency: n/a (wiring only).
// Backpressure: none; enable gates launches, events are counted regardless.
// Ports: prize_sense, enable (toward DUT); increment_score_pe, pending, overflow (from DUT).
interface score_event_gen_if #(
  parameter int PEND_W = 4
);
  logic              prize_sense;
  logic              enable;
  logic              increment_score_pe;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  // master: the cabinet / processor side driving the sensor and enable
  modport master (
    output prize_sense,
    output enable,
    input  increment_score_pe,
    input  pending,
    input  overflow
  );

  // slave: the score event generator itself
  modport slave (
    input  prize_sense,
    input  enable,
    output increment_score_pe,
    output pending,
    output overflow
  );
endinterface

// File: rtl/prize_debounce.sv
// Synchronize and debounce the raw prize sensor; emit a one-cycle ev on each debounced rising edge.
// Latency: ev high after edge DEBOUNCE_CYCLES+1 when input is first sampled high at edge 0.
// Backpressure: none; ev is a fire-and-forget strobe.
// Ports: clock, reset (sync, active-high), prize_sense (async raw level), ev (out, 1 cycle).
module prize_debounce
  import score_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic prize_sense,
  output logic ev
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic          db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= prize_sense;
      s2   <= s1;
      db_q <= db;
      // Any sample agreeing with the current level restarts the run, so only
      // DEBOUNCE_CYCLES consecutive disagreeing samples move db.
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Rising edges only: a prize leaving the sensor is not a score event.
  assign ev = db & ~db_q;

endmodule

// File: rtl/score_event_gen.sv
// Turn debounced prize drops into spaced single-cycle increment_score_pe pulses.
// Latency: pulse high after edge DEBOUNCE_CYCLES+3 from first high sample; pulses >= GAP_CYCLES+1 apart.
// Backpressure: enable low holds launches; events keep queuing in pending (saturating, sticky overflow).
// Ports: clock, reset (sync, active-high), bus (slave: prize_sense, enable in; pulse, pending, overflow out).
module score_event_gen
  import score_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int PEND_W          = DEF_PEND_W
) (
  input  logic               clock,
  input  logic               reset,
  score_event_gen_if.slave   bus
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]     GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic              ev;
  logic              dec;
  logic              launch_ok;
  logic [PEND_W-1:0] pending_q;
  logic              overflow_q;
  state_t            state_q;
  state_t            state_nxt;
  logic [GW-1:0]     gcnt_q;
  logic [GW-1:0]     gcnt_nxt;
  logic              pulse_q;

  prize_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock       (clock),
    .reset       (reset),
    .prize_sense (bus.prize_sense),
    .ev          (ev)
  );

  // The event is consumed on the edge that leaves PULSE.
  assign dec       = (state_q == PULSE);
  assign launch_ok = bus.enable && (pending_q != '0);

  // Pending counter: a coincident event and decrement cancel out, and that
  // case never flags overflow because nothing is actually lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (ev && !dec) begin
        if (pending_q == PEND_MAX) begin
          overflow_q <= 1'b1;
        end else begin
          pending_q <= pending_q + 1'b1;
        end
      end else if (dec && !ev) begin
        pending_q <= pending_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    gcnt_nxt  = gcnt_q;
    case (state_q)
      IDLE: begin
        if (launch_ok) begin
          state_nxt = PULSE;
        end
      end
      PULSE: begin
        state_nxt = GAP;
        gcnt_nxt  = '0;
      end
      GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_nxt = launch_ok ? PULSE : IDLE;
          gcnt_nxt  = '0;
        end else begin
          gcnt_nxt = gcnt_q + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      gcnt_q  <= gcnt_nxt;
      // Registered copy of "in PULSE" so the processor sees a clean flop output.
      pulse_q <= (state_nxt == PULSE);
    end
  end

  assign bus.increment_score_pe = pulse_q;
  assign bus.pending            = pending_q;
  assign bus.overflow           = overflow_q;

endmodule

// File: tb/tb_score_event_gen.sv
// Bench for score_event_gen: two instances (PEND_W 4 and 2) share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_score_event_gen;
  import score_pkg::*;

  localparam int DB     = 16;
  localparam int GAP    = 4;
  localparam int PERIOD = GAP + 1;

  logic clk;
  logic rst;
  logic prize;
  logic en;

  int total = 0;
  int bad   = 0;

  score_event_gen_if #(.PEND_W(4)) bus_a ();
  score_event_gen_if #(.PEND_W(2)) bus_b ();

  assign bus_a.prize_sense = prize;
  assign bus_a.enable      = en;
  assign bus_b.prize_sense = prize;
  assign bus_b.enable      = en;

  score_event_gen #(.DEBOUNCE_CYCLES(DB), .GAP_CYCLES(GAP), .PEND_W(4)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (bus_a.slave)
  );

  score_event_gen #(.DEBOUNCE_CYCLES(DB), .GAP_CYCLES(GAP), .PEND_W(2)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. Debounced level flips at edge m when the raw samples
  // taken at edges m-17 .. m-2 all disagree with it; a rise is counted one edge
  // later; a pulse may launch whenever work is pending, enable is high and at
  // least PERIOD edges have passed since the previous launch.
  bit hist[$];
  int cyc_n = 0;
  bit m_db[2];
  bit m_rose[2];
  bit m_pulse[2];
  int m_last[2];
  int m_pend[2];
  bit m_ovf[2];
  int m_pmax[2] = '{15, 3};

  task automatic model_step();
    bit flip;
    bit launch;
    bit ev;
    bit dec;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_db[k] = 1'b0; m_rose[k] = 1'b0; m_pulse[k] = 1'b0;
        m_last[k] = -1000; m_pend[k] = 0; m_ovf[k] = 1'b0;
      end
      hist.delete();
      repeat (DB + 1) hist.push_back(1'b0);
    end else begin
      for (int k = 0; k < 2; k++) begin
        ev     = m_rose[k];
        dec    = m_pulse[k];
        launch = en && (m_pend[k] > 0) && (cyc_n - m_last[k] >= PERIOD);
        flip   = 1'b1;
        for (int i = 0; i < DB; i++) if (hist[i] == m_db[k]) flip = 1'b0;
        if (ev && !dec) begin
          if (m_pend[k] == m_pmax[k]) m_ovf[k] = 1'b1;
          else m_pend[k]++;
        end else if (dec && !ev) begin
          m_pend[k]--;
        end
        m_pulse[k] = launch;
        if (launch) m_last[k] = cyc_n;
        m_rose[k] = flip && !m_db[k];
        if (flip) m_db[k] = !m_db[k];
      end
      hist.push_back(prize);
      void'(hist.pop_front());
    end
    cyc_n++;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_pulse_a", int'(bus_a.increment_score_pe), int'(m_pulse[0]));
    chk("model_pend_a",  int'(bus_a.pending),            m_pend[0]);
    chk("model_ovf_a",   int'(bus_a.overflow),           int'(m_ovf[0]));
    chk("model_pulse_b", int'(bus_b.increment_score_pe), int'(m_pulse[1]));
    chk("model_pend_b",  int'(bus_b.pending),            m_pend[1]);
    chk("model_ovf_b",   int'(bus_b.overflow),           int'(m_ovf[1]));
  endtask

  typedef struct {
    bit lvl;
    bit en;
    int n;
    int pend_a;
    int pend_b;
    int pulses_a;
    int pulses_b;
    bit ovf_b;
  } row_t;

  function automatic row_t mk(bit lvl, bit e, int n, int pa, int pb, int qa, int qb, bit ob);
    row_t r;
    r.lvl = lvl; r.en = e; r.n = n; r.pend_a = pa; r.pend_b = pb;
    r.pulses_a = qa; r.pulses_b = qb; r.ovf_b = ob;
    return r;
  endfunction

  row_t tbl[18];
  int   rec_pend[40];
  int   rec_pulse[40];

  initial begin
    int cnt_a;
    int cnt_b;
    int sum;
    bit found;

    rst = 1'b1; prize = 1'b0; en = 1'b0;

    // Reset state
    cyc();
    chk("reset_pulse", int'(bus_a.increment_score_pe), 0);
    chk("reset_pend",  int'(bus_a.pending), 0);
    chk("reset_ovf",   int'(bus_a.overflow), 0);

    // Latency of a single clean press, edge 0 = first high sample
    rst = 1'b0; en = 1'b1; prize = 1'b1;
    for (int e = 0; e < 40; e++) begin
      cyc();
      rec_pend[e]  = int'(bus_a.pending);
      rec_pulse[e] = int'(bus_a.increment_score_pe);
    end
    chk("lat_pend_e17",  rec_pend[17], 0);
    chk("lat_pend_e18",  rec_pend[18], 1);
    chk("lat_pulse_e18", rec_pulse[18], 0);
    chk("lat_pulse_e19", rec_pulse[19], 1);
    chk("lat_pulse_e20", rec_pulse[20], 0);
    chk("lat_pend_e20",  rec_pend[20], 0);
    sum = 0;
    for (int e = 0; e < 40; e++) sum += rec_pulse[e];
    chk("lat_pulse_count", sum, 1);
    chk("lat_ovf", int'(bus_a.overflow), 0);

    // Table: bounce, chatter, queued presses with enable low, saturation, drain
    tbl[0]  = mk(1'b0, 1'b1, 40, 0, 0, 0, 0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b1, 10, 0, 0, 0, 0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1,  5, 0, 0, 0, 0, 1'b0);
    tbl[3]  = mk(1'b1, 1'b1, 12, 0, 0, 0, 0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1,  3, 0, 0, 0, 0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b1, 15, 0, 0, 0, 0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 40, 0, 0, 0, 0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 40, 1, 1, 0, 0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 40, 1, 1, 0, 0, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 40, 2, 2, 0, 0, 1'b0);
    tbl[10] = mk(1'b0, 1'b0, 40, 2, 2, 0, 0, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 40, 3, 3, 0, 0, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 40, 3, 3, 0, 0, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 40, 4, 3, 0, 0, 1'b1);
    tbl[14] = mk(1'b0, 1'b0, 40, 4, 3, 0, 0, 1'b1);
    tbl[15] = mk(1'b1, 1'b0, 40, 5, 3, 0, 0, 1'b1);
    tbl[16] = mk(1'b0, 1'b0, 40, 5, 3, 0, 0, 1'b1);
    tbl[17] = mk(1'b0, 1'b1, 40, 0, 0, 5, 3, 1'b1);
    for (int r = 0; r < 18; r++) begin
      prize = tbl[r].lvl; en = tbl[r].en;
      cnt_a = 0; cnt_b = 0;
      repeat (tbl[r].n) begin
        cyc();
        cnt_a += int'(bus_a.increment_score_pe);
        cnt_b += int'(bus_b.increment_score_pe);
      end
      chk($sformatf("row%0d_pend_a", r),   int'(bus_a.pending), tbl[r].pend_a);
      chk($sformatf("row%0d_pend_b", r),   int'(bus_b.pending), tbl[r].pend_b);
      chk($sformatf("row%0d_pulses_a", r), cnt_a, tbl[r].pulses_a);
      chk($sformatf("row%0d_pulses_b", r), cnt_b, tbl[r].pulses_b);
      chk($sformatf("row%0d_ovf_b", r),    int'(bus_b.overflow), int'(tbl[r].ovf_b));
    end

    // Reset while in GAP with two events still pending
    en = 1'b0;
    repeat (3) begin
      prize = 1'b1; repeat (40) cyc();
      prize = 1'b0; repeat (40) cyc();
    end
    chk("gap_setup_pend", int'(bus_a.pending), 3);
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (bus_a.increment_score_pe) found = 1'b1;
    end
    chk("gap_launch_seen", int'(found), 1);
    cyc();
    chk("gap_pend_before_reset", int'(bus_a.pending), 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("gap_reset_state", int'(dut_a.state_q), int'(IDLE));
    chk("gap_reset_pend",  int'(bus_a.pending), 0);
    chk("gap_reset_pulse", int'(bus_a.increment_score_pe), 0);
    chk("gap_reset_ovf_b", int'(bus_b.overflow), 0);
    cnt_a = 0;
    repeat (40) begin
      cyc();
      cnt_a += int'(bus_a.increment_score_pe);
    end
    chk("gap_no_more_pulses", cnt_a, 0);

    // Event landing on the same edge as the PULSE decrement, pending = 1
    en = 1'b0;
    prize = 1'b1; repeat (40) cyc();
    prize = 1'b0; repeat (40) cyc();
    chk("coin_setup_pend", int'(bus_a.pending), 1);
    prize = 1'b1;
    for (int e = 0; e < 40; e++) begin
      en = (e >= 17);
      cyc();
      rec_pend[e]  = int'(bus_a.pending);
      rec_pulse[e] = int'(bus_a.increment_score_pe);
    end
    chk("coin_pulse_e17", rec_pulse[17], 1);
    chk("coin_pend_e18",  rec_pend[18], 1);
    sum = 0;
    for (int e = 18; e < 22; e++) sum += rec_pulse[e];
    chk("coin_gap_quiet", sum, 0);
    chk("coin_pulse_e22", rec_pulse[22], 1);
    chk("coin_pend_e23",  rec_pend[23], 0);
    chk("coin_ovf",       int'(bus_a.overflow), 0);

    // Randomized segments, with occasional resets, against the model
    prize = 1'b0;
    for (int s = 0; s < 90; s++) begin
      prize = 1'($urandom_range(0, 1));
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 45)) cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
